chip8_mem_sched: RTL and testbench

CHIP8_MEM_SCHED -- requirements
Module: chip8_mem_sched

---
 rtl/chip8_pkg.sv | 25 ++
 rtl/arb_rr2.sv | 41 ++++
 rtl/chip8_mem_sched.sv | 115 +++++++++++
 tb/tb_chip8_mem_sched.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: scheduler states, program base and opcode classes.
// Pure constants and types; no logic.
package chip8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } sched_state_t;

    localparam int PROG_BASE = 512;

    // Opcode class = upper nibble of the first instruction byte
    localparam logic [3:0] OP_SYS  = 4'h0;
    localparam logic [3:0] OP_JP   = 4'h1;
    localparam logic [3:0] OP_CALL = 4'h2;
    localparam logic [3:0] OP_SE   = 4'h3;
    localparam logic [3:0] OP_SNE  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ADD  = 4'h7;
    localparam logic [3:0] OP_ALU  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_DRW  = 4'hD;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin arbiter (fetch vs draw) with a draw burst lock.
// Zero-latency grant from req; losers simply retry, nothing is queued.
module arb_rr2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic fetch_req,
    input  logic draw_req,
    input  logic draw_lock,
    output logic fetch_gnt,
    output logic draw_gnt
);

    logic last_draw;

    always_comb begin
        fetch_gnt = 1'b0;
        draw_gnt  = 1'b0;
        if (en) begin
            // A locked burst keeps the port only if draw already owns it
            if (draw_req && draw_lock && last_draw) begin
                draw_gnt = 1'b1;
            end else if (fetch_req && draw_req) begin
                draw_gnt  = !last_draw;
                fetch_gnt = last_draw;
            end else begin
                fetch_gnt = fetch_req;
                draw_gnt  = draw_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_draw <= 1'b0;
        end else if (fetch_gnt || draw_gnt) begin
            last_draw <= draw_gnt;
        end
    end

endmodule

// File: rtl/chip8_mem_sched.sv
// Program-load FSM plus fetch/draw read scheduler for the CHIP-8 memory port.
// Grants are combinational; rvalid/rdata follow a grant by 2 cycles; UART bytes are never stalled.
module chip8_mem_sched #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int PROG_BASE  = chip8_pkg::PROG_BASE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_i,
    input  logic                  rx_i_v,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_len,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    input  logic                  draw_req,
    input  logic [ADDR_WIDTH-1:0] draw_addr,
    input  logic                  draw_lock,
    output logic                  draw_gnt,
    output logic                  draw_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_d,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  cpu_run,
    output logic                  load_busy,
    output logic                  load_ovf
);
    import chip8_pkg::*;

    localparam int PW = ADDR_WIDTH + 1;

    sched_state_t          state;
    // Extra MSB marks "past top of memory" so the pointer never wraps
    logic [PW-1:0]         ptr;
    logic [ADDR_WIDTH-1:0] count;
    logic [ADDR_WIDTH-1:0] count_nxt;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic                  byte_in;
    logic                  fetch_p1;
    logic                  draw_p1;

    assign byte_in   = (state == ST_LOAD) && rx_i_v && !load_start;
    assign count_nxt = count + 1'b1;
    assign mem_we    = byte_in && !ptr[ADDR_WIDTH];
    assign mem_waddr = mem_we ? ptr[ADDR_WIDTH-1:0] : '0;
    assign mem_d     = mem_we ? DATA_WIDTH'(rx_i) : '0;
    assign cpu_run   = (state == ST_RUN);
    assign load_busy = (state == ST_LOAD);

    arb_rr2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (cpu_run),
        .fetch_req (fetch_req),
        .draw_req  (draw_req),
        .draw_lock (draw_lock),
        .fetch_gnt (fetch_gnt),
        .draw_gnt  (draw_gnt)
    );

    assign mem_raddr = fetch_gnt ? fetch_addr :
                       draw_gnt  ? draw_addr  : raddr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= PW'(PROG_BASE);
            count    <= '0;
            len_q    <= '0;
            load_ovf <= 1'b0;
        end else if (load_start) begin
            ptr      <= PW'(PROG_BASE);
            count    <= '0;
            len_q    <= load_len;
            load_ovf <= 1'b0;
            state    <= (load_len == '0) ? ST_RUN : ST_LOAD;
        end else if (byte_in) begin
            count <= count_nxt;
            if (ptr[ADDR_WIDTH]) begin
                load_ovf <= 1'b1;
            end else begin
                ptr <= ptr + PW'(1);
            end
            if (count_nxt == len_q) begin
                state <= ST_RUN;
            end
        end
    end

    // Grant pipe runs independently of state so an issued read always returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q      <= '0;
            rdata        <= '0;
            fetch_p1     <= 1'b0;
            draw_p1      <= 1'b0;
            fetch_rvalid <= 1'b0;
            draw_rvalid  <= 1'b0;
        end else begin
            raddr_q      <= mem_raddr;
            rdata        <= mem_q;
            fetch_p1     <= fetch_gnt;
            draw_p1      <= draw_gnt;
            fetch_rvalid <= fetch_p1;
            draw_rvalid  <= draw_p1;
        end
    end

endmodule

// File: tb/tb_chip8_mem_sched.sv
// Randomised bench for chip8_mem_sched with a behavioural memory and scheduler model.
// A second instance based at 0xFFE covers the top-of-memory overflow case.
module tb_chip8_mem_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_i = '0;
    logic        rx_i_v = 1'b0, load_start = 1'b0;
    logic [11:0] load_len = '0;
    logic        fetch_req = 1'b0, draw_req = 1'b0, draw_lock = 1'b0;
    logic [11:0] fetch_addr = '0, draw_addr = '0;
    logic        fetch_gnt, fetch_rvalid, draw_gnt, draw_rvalid;
    logic [7:0]  rdata, mem_d;
    logic        mem_we, cpu_run, load_busy, load_ovf;
    logic [11:0] mem_waddr, mem_raddr;
    logic [7:0]  mem_q;

    logic [7:0]  o_rx_i = '0;
    logic        o_rx_i_v = 1'b0, o_load_start = 1'b0;
    logic [11:0] o_load_len = '0;
    logic        o_fetch_gnt, o_fetch_rvalid, o_draw_gnt, o_draw_rvalid;
    logic [7:0]  o_rdata, o_mem_d;
    logic        o_mem_we, o_cpu_run, o_load_busy, o_load_ovf;
    logic [11:0] o_mem_waddr, o_mem_raddr;
    logic [7:0]  o_mem_q = '0;
    logic        o_zero = 1'b0;
    logic [11:0] o_zaddr = '0;

    int passes = 0;
    int checks = 0;

    logic [7:0]  mem [4096];
    logic [7:0]  exp_mem [4096];
    bit          m_last_draw = 1'b0;
    logic [11:0] m_raddr = '0;

    bit          a_fr [64], a_dr [64], a_lk [64];
    logic [11:0] a_fa [64], a_da [64];
    int          act_seq [64];

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the address
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_d;
        mem_q <= mem[mem_raddr];
    end

    chip8_mem_sched dut (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .rx_i_v(rx_i_v),
        .load_start(load_start), .load_len(load_len),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .draw_req(draw_req), .draw_addr(draw_addr),
        .draw_lock(draw_lock), .draw_gnt(draw_gnt), .draw_rvalid(draw_rvalid),
        .rdata(rdata), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_d(mem_d),
        .mem_raddr(mem_raddr), .mem_q(mem_q), .cpu_run(cpu_run),
        .load_busy(load_busy), .load_ovf(load_ovf)
    );

    chip8_mem_sched #(.PROG_BASE(12'hFFE)) u_ovf (
        .clk(clk), .rst_n(rst_n), .rx_i(o_rx_i), .rx_i_v(o_rx_i_v),
        .load_start(o_load_start), .load_len(o_load_len),
        .fetch_req(o_zero), .fetch_addr(o_zaddr), .fetch_gnt(o_fetch_gnt),
        .fetch_rvalid(o_fetch_rvalid), .draw_req(o_zero), .draw_addr(o_zaddr),
        .draw_lock(o_zero), .draw_gnt(o_draw_gnt), .draw_rvalid(o_draw_rvalid),
        .rdata(o_rdata), .mem_we(o_mem_we), .mem_waddr(o_mem_waddr), .mem_d(o_mem_d),
        .mem_raddr(o_mem_raddr), .mem_q(o_mem_q), .cpu_run(o_cpu_run),
        .load_busy(o_load_busy), .load_ovf(o_load_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] v;
        fetch_req = 1'b1; fetch_addr = 12'h345; draw_req = 1'b1; rx_i_v = 1'b1; rx_i = 8'hA5;
        tick(); #2;
        v = {fetch_gnt, fetch_rvalid, draw_gnt, draw_rvalid, rdata, mem_we, mem_waddr,
             mem_d, mem_raddr, cpu_run, load_busy, load_ovf};
        checks++; if (v !== '0) $display("FAIL reset_outputs: got %0h want 0", v); else passes++;
        rst_n = 1'b1;
        tick(); #2;
        checks++; if ({fetch_gnt, draw_gnt} !== 2'b00) $display("FAIL idle_no_grant: got %b want 00", {fetch_gnt, draw_gnt}); else passes++;
        checks++; if (mem_we !== 1'b0) $display("FAIL idle_rx_ignored: mem_we got %b want 0", mem_we); else passes++;
        checks++; if ({cpu_run, load_busy} !== 2'b00) $display("FAIL idle_state: got %b want 00", {cpu_run, load_busy}); else passes++;
        fetch_req = 1'b0; draw_req = 1'b0; rx_i_v = 1'b0;
    endtask

    task automatic test_load(input int len, input bit fixed);
        logic [7:0] tbl [3];
        logic [7:0] b;
        logic [11:0] ea;
        tbl[0] = 8'h12; tbl[1] = 8'h34; tbl[2] = 8'h56;
        tick(); load_start = 1'b1; load_len = 12'(len);
        tick(); load_start = 1'b0;
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) begin
                #2;
                checks++; if ({mem_we, cpu_run, load_busy} !== 3'b001) $display("FAIL load_gap: we/run/busy got %b want 001", {mem_we, cpu_run, load_busy}); else passes++;
                tick();
            end
            b = fixed ? tbl[i] : 8'($urandom);
            ea = 12'(512 + i);
            rx_i = b; rx_i_v = 1'b1;
            #2;
            checks++; if ({mem_we, mem_waddr, mem_d} !== {1'b1, ea, b}) $display("FAIL load_write[%0d]: got we=%b a=%h d=%h want we=1 a=%h d=%h", i, mem_we, mem_waddr, mem_d, ea, b); else passes++;
            checks++; if (cpu_run !== 1'b0) $display("FAIL load_early_run[%0d]: got %b want 0", i, cpu_run); else passes++;
            exp_mem[ea] = b;
            tick(); rx_i_v = 1'b0;
        end
        #2;
        checks++; if ({cpu_run, load_busy, load_ovf} !== 3'b100) $display("FAIL load_done: run/busy/ovf got %b want 100", {cpu_run, load_busy, load_ovf}); else passes++;
    endtask

    task automatic test_load_zero();
        tick(); load_start = 1'b1; load_len = 12'd0;
        tick(); load_start = 1'b0; #2;
        checks++; if ({cpu_run, load_busy} !== 2'b10) $display("FAIL load_zero: run/busy got %b want 10", {cpu_run, load_busy}); else passes++;
    endtask

    task automatic run_arb(input int n);
        int          eg [66];
        logic [11:0] ea [66];
        int          e;
        for (int k = 0; k < n + 2; k++) begin
            tick();
            fetch_req = (k < n) ? a_fr[k] : 1'b0;
            draw_req  = (k < n) ? a_dr[k] : 1'b0;
            draw_lock = (k < n) ? a_lk[k] : 1'b0;
            fetch_addr = (k < n) ? a_fa[k] : 12'h0;
            draw_addr  = (k < n) ? a_da[k] : 12'h0;
            #2;
            e = 0;
            if (k < n) begin
                if (a_dr[k] && a_lk[k] && m_last_draw) e = 2;
                else if (a_fr[k] && a_dr[k]) e = m_last_draw ? 1 : 2;
                else if (a_fr[k]) e = 1;
                else if (a_dr[k]) e = 2;
            end
            if (e != 0) begin
                m_last_draw = (e == 2);
                m_raddr = (e == 1) ? a_fa[k] : a_da[k];
            end
            eg[k] = e; ea[k] = m_raddr;
            act_seq[k] = draw_gnt ? 2 : (fetch_gnt ? 1 : 0);
            checks++; if ({fetch_gnt, draw_gnt} !== {e == 1, e == 2}) $display("FAIL arb_grant[%0d]: f/d got %b%b want %b%b", k, fetch_gnt, draw_gnt, e == 1, e == 2); else passes++;
            checks++; if (mem_raddr !== m_raddr) $display("FAIL arb_raddr[%0d]: got %h want %h", k, mem_raddr, m_raddr); else passes++;
            if (k >= 2) begin
                checks++; if ({fetch_rvalid, draw_rvalid} !== {eg[k-2] == 1, eg[k-2] == 2}) $display("FAIL arb_rvalid[%0d]: f/d got %b%b want %b%b", k, fetch_rvalid, draw_rvalid, eg[k-2] == 1, eg[k-2] == 2); else passes++;
                if (eg[k-2] != 0) begin
                    checks++; if (rdata !== exp_mem[ea[k-2]]) $display("FAIL arb_rdata[%0d]: got %h want %h", k, rdata, exp_mem[ea[k-2]]); else passes++;
                end
            end else begin
                checks++; if ({fetch_rvalid, draw_rvalid} !== 2'b00) $display("FAIL arb_rvalid_idle[%0d]: got %b%b want 00", k, fetch_rvalid, draw_rvalid); else passes++;
            end
        end
    endtask

    task automatic test_contention();
        for (int k = 0; k < 4; k++) begin
            a_fr[k] = 1'b1; a_dr[k] = 1'b1; a_lk[k] = 1'b0;
            a_fa[k] = 12'(512 + $urandom_range(0, 23));
            a_da[k] = 12'(512 + $urandom_range(0, 23));
        end
        run_arb(4);
        for (int k = 0; k < 4; k++) begin
            checks++; if (act_seq[k] !== ((k % 2 == 0) ? 2 : 1)) $display("FAIL contention_order[%0d]: got %0d want %0d (1=F 2=D)", k, act_seq[k], (k % 2 == 0) ? 2 : 1); else passes++;
        end
    endtask

    task automatic test_lock();
        for (int k = 0; k < 4; k++) begin
            a_fr[k] = 1'b1; a_dr[k] = 1'b1; a_lk[k] = (k < 3);
            a_fa[k] = 12'(512 + $urandom_range(0, 23));
            a_da[k] = 12'(512 + $urandom_range(0, 23));
        end
        run_arb(4);
        for (int k = 0; k < 4; k++) begin
            checks++; if (act_seq[k] !== ((k < 3) ? 2 : 1)) $display("FAIL lock_order[%0d]: got %0d want %0d (1=F 2=D)", k, act_seq[k], (k < 3) ? 2 : 1); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) begin
            a_fr[k] = ($urandom_range(0, 3) != 0);
            a_dr[k] = ($urandom_range(0, 3) != 0);
            a_lk[k] = $urandom_range(0, 1) == 1;
            a_fa[k] = 12'(512 + $urandom_range(0, 23));
            a_da[k] = 12'(512 + $urandom_range(0, 23));
        end
        run_arb(40);
    endtask

    task automatic test_load_during_run();
        logic [11:0] a, da;
        logic [7:0]  b;
        a = 12'(512 + $urandom_range(0, 23));
        da = 12'(512 + $urandom_range(0, 23));
        tick();
        fetch_req = 1'b1; fetch_addr = a; draw_req = 1'b0; draw_lock = 1'b0;
        load_start = 1'b1; load_len = 12'd2;
        #2;
        checks++; if ({fetch_gnt, draw_gnt} !== 2'b10) $display("FAIL ldrun_grant: got %b%b want 10", fetch_gnt, draw_gnt); else passes++;
        m_last_draw = 1'b0; m_raddr = a;
        tick(); load_start = 1'b0; draw_req = 1'b1; draw_addr = da; #2;
        checks++; if ({fetch_gnt, draw_gnt, load_busy} !== 3'b001) $display("FAIL ldrun_blocked: f/d/busy got %b%b%b want 001", fetch_gnt, draw_gnt, load_busy); else passes++;
        tick(); #2;
        checks++; if (fetch_rvalid !== 1'b1) $display("FAIL ldrun_rvalid: got %b want 1", fetch_rvalid); else passes++;
        checks++; if (rdata !== exp_mem[a]) $display("FAIL ldrun_rdata: got %h want %h", rdata, exp_mem[a]); else passes++;
        for (int i = 0; i < 2; i++) begin
            tick(); b = 8'($urandom); rx_i = b; rx_i_v = 1'b1; #2;
            checks++; if ({fetch_gnt, draw_gnt, mem_we} !== 3'b001) $display("FAIL ldrun_load[%0d]: f/d/we got %b%b%b want 001", i, fetch_gnt, draw_gnt, mem_we); else passes++;
            exp_mem[12'(512 + i)] = b;
        end
        tick(); rx_i_v = 1'b0; #2;
        checks++; if ({cpu_run, fetch_gnt, draw_gnt} !== {1'b1, m_last_draw, !m_last_draw}) $display("FAIL ldrun_resume: run/f/d got %b%b%b want 1%b%b", cpu_run, fetch_gnt, draw_gnt, m_last_draw, !m_last_draw); else passes++;
        m_raddr = m_last_draw ? a : da;
        m_last_draw = !m_last_draw;
        tick(); fetch_req = 1'b0; draw_req = 1'b0;
        tick(); #2;
        checks++; if ({fetch_rvalid, draw_rvalid} !== {!m_last_draw, m_last_draw}) $display("FAIL ldrun_resume_rvalid: got %b%b want %b%b", fetch_rvalid, draw_rvalid, !m_last_draw, m_last_draw); else passes++;
        checks++; if (rdata !== exp_mem[m_raddr]) $display("FAIL ldrun_resume_rdata: got %h want %h", rdata, exp_mem[m_raddr]); else passes++;
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        int         addr;
        bit         ewe, m_ovf;
        m_ovf = 1'b0;
        tick(); o_load_start = 1'b1; o_load_len = 12'd4;
        tick(); o_load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom); addr = 4094 + i; ewe = (addr < 4096);
            o_rx_i = b; o_rx_i_v = 1'b1; #2;
            checks++; if (o_mem_we !== ewe) $display("FAIL ovf_we[%0d]: got %b want %b", i, o_mem_we, ewe); else passes++;
            if (ewe) begin
                checks++; if ({o_mem_waddr, o_mem_d} !== {12'(addr), b}) $display("FAIL ovf_write[%0d]: got a=%h d=%h want a=%h d=%h", i, o_mem_waddr, o_mem_d, 12'(addr), b); else passes++;
            end
            checks++; if (o_load_ovf !== m_ovf) $display("FAIL ovf_flag[%0d]: got %b want %b", i, o_load_ovf, m_ovf); else passes++;
            if (!ewe) m_ovf = 1'b1;
            tick(); o_rx_i_v = 1'b0;
        end
        #2;
        checks++; if ({o_load_ovf, o_cpu_run} !== 2'b11) $display("FAIL ovf_done: ovf/run got %b%b want 11", o_load_ovf, o_cpu_run); else passes++;
        tick(); o_load_start = 1'b1; o_load_len = 12'd0;
        tick(); o_load_start = 1'b0; #2;
        checks++; if ({o_load_ovf, o_cpu_run} !== 2'b01) $display("FAIL ovf_clear: ovf/run got %b%b want 01", o_load_ovf, o_cpu_run); else passes++;
    endtask

    task automatic test_reset_midload();
        logic [63:0] v;
        tick(); load_start = 1'b1; load_len = 12'd5;
        tick(); load_start = 1'b0; rx_i = 8'h77; rx_i_v = 1'b1; #2;
        checks++; if (mem_we !== 1'b1) $display("FAIL midload_first_byte: we got %b want 1", mem_we); else passes++;
        tick(); rx_i_v = 1'b0; #2;
        checks++; if (load_busy !== 1'b1) $display("FAIL midload_busy: got %b want 1", load_busy); else passes++;
        #1 rst_n = 1'b0; #1;
        v = {fetch_gnt, fetch_rvalid, draw_gnt, draw_rvalid, rdata, mem_we, mem_waddr,
             mem_d, mem_raddr, cpu_run, load_busy, load_ovf};
        checks++; if (v !== '0) $display("FAIL midload_reset_outputs: got %0h want 0", v); else passes++;
        tick(); tick(); rst_n = 1'b1;
        tick(); rx_i_v = 1'b1; fetch_req = 1'b1; #2;
        checks++; if ({mem_we, cpu_run, load_busy, fetch_gnt} !== 4'b0000) $display("FAIL midload_idle: we/run/busy/gnt got %b%b%b%b want 0000", mem_we, cpu_run, load_busy, fetch_gnt); else passes++;
        tick(); rx_i_v = 1'b0; fetch_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) exp_mem[i] = 8'h00;
        test_reset();
        test_load(3, 1'b1);
        test_load(24, 1'b0);
        test_load_zero();
        test_contention();
        test_lock();
        test_back_to_back();
        test_load_during_run();
        test_overflow();
        test_reset_midload();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
